// File: rtl/noisy_channel_mc.sv
// noisy_channel_mc
// Multi-lane error-injecting serial channel. Each lane registers its input bit
// once and optionally corrupts it using a per-lane 16-bit LFSR: random flips,
// fixed-length bursts, or stuck-at. Each lane also has a saturating error counter.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in         in   [NUM_CH]   serial input, one bit per lane
//   ch_en      in   [NUM_CH]   per-lane impairment enable (0 = clean pass-through)
//   mode       in   [2]        00 off, 01 random flip, 10 burst, 11 stuck-at
//   err_rate   in   [8]        trigger when lfsr[7:0] < err_rate
//   stuck_val  in   [NUM_CH]   forced level per lane in stuck-at mode
//   reseed     in   reload every LFSR with its lane seed
//   clr_cnt    in   clear every error counter (wins over increment)
//   out        out  [NUM_CH]   registered, impaired serial output
//   err_flag   out  [NUM_CH]   out differs from the input bit that produced it
//   err_cnt    out  [16*NUM_CH] saturating error counts, lane i at [16i+15:16i]
//
// Burst FSM (one per lane)
//   state    | meaning
//   ST_IDLE  | waiting for a trigger; a trigger flips this cycle
//   ST_BURST | flipping every cycle, bcnt counts remaining flips down to 1
module noisy_channel_mc #(
    parameter int unsigned NUM_CH    = 2,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned BURST_LEN = 4,
    parameter logic        IDLE_VAL  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      in,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [1:0]             mode,
    input  logic [7:0]             err_rate,
    input  logic [NUM_CH-1:0]      stuck_val,
    input  logic                   reseed,
    input  logic                   clr_cnt,
    output logic [NUM_CH-1:0]      out,
    output logic [NUM_CH-1:0]      err_flag,
    output logic [16*NUM_CH-1:0]   err_cnt
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_RAND  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [7:0] BURST_RELOAD = 8'(BURST_LEN - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_st_t;

    // Lane seed = SEED rotated left by the lane index.
    function automatic logic [15:0] lane_seed(input int unsigned lane);
        logic [31:0] dbl;
        dbl = {SEED, SEED} << lane;
        return dbl[31:16];
    endfunction

    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] err_flag_q, err_flag_d;
    logic [15:0]       lfsr_q [NUM_CH];
    logic [15:0]       lfsr_d [NUM_CH];
    logic [15:0]       cnt_q  [NUM_CH];
    logic [15:0]       cnt_d  [NUM_CH];
    logic [7:0]        bcnt_q [NUM_CH];
    logic [7:0]        bcnt_d [NUM_CH];
    burst_st_t         st_q   [NUM_CH];
    burst_st_t         st_d   [NUM_CH];

    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] flip;

    always_comb begin
        active     = '0;
        trig       = '0;
        flip       = '0;
        out_d      = out_q;
        err_flag_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            lfsr_d[i] = reseed ? lane_seed(i)
                               : {lfsr_q[i][14:0],
                                  lfsr_q[i][15] ^ lfsr_q[i][13] ^ lfsr_q[i][12] ^ lfsr_q[i][10]};
            st_d[i]   = ST_IDLE;
            bcnt_d[i] = bcnt_q[i];

            // Trigger uses the pre-advance LFSR value, so a reseed edge can still flip.
            trig[i]   = (lfsr_q[i][7:0] < err_rate);
            active[i] = ch_en[i] && (mode != MODE_OFF);

            // Any cycle that is not an active burst-mode cycle drops the FSM to IDLE.
            if (active[i] && (mode == MODE_BURST)) begin
                if (st_q[i] == ST_BURST) begin
                    flip[i]   = 1'b1;
                    bcnt_d[i] = bcnt_q[i] - 8'd1;
                    st_d[i]   = (bcnt_q[i] == 8'd1) ? ST_IDLE : ST_BURST;
                end else if (trig[i]) begin
                    flip[i] = 1'b1;
                    if (BURST_LEN > 1) begin
                        st_d[i]   = ST_BURST;
                        bcnt_d[i] = BURST_RELOAD;
                    end
                end
            end

            if (!active[i]) begin
                out_d[i]      = in[i];
                err_flag_d[i] = 1'b0;
            end else if (mode == MODE_RAND) begin
                out_d[i]      = in[i] ^ trig[i];
                err_flag_d[i] = trig[i];
            end else if (mode == MODE_BURST) begin
                out_d[i]      = in[i] ^ flip[i];
                err_flag_d[i] = flip[i];
            end else begin
                out_d[i]      = stuck_val[i];
                err_flag_d[i] = stuck_val[i] ^ in[i];
            end

            // Counter follows the registered flag, so it trails out by one cycle.
            if (clr_cnt) begin
                cnt_d[i] = 16'd0;
            end else if (err_flag_q[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= {NUM_CH{IDLE_VAL}};
            err_flag_q <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                lfsr_q[i] <= lane_seed(i);
                cnt_q[i]  <= 16'd0;
                bcnt_q[i] <= 8'd0;
                st_q[i]   <= ST_IDLE;
            end
        end else begin
            out_q      <= out_d;
            err_flag_q <= err_flag_d;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                lfsr_q[i] <= lfsr_d[i];
                cnt_q[i]  <= cnt_d[i];
                bcnt_q[i] <= bcnt_d[i];
                st_q[i]   <= st_d[i];
            end
        end
    end

    assign out      = out_q;
    assign err_flag = err_flag_q;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cnt
        assign err_cnt[16*g +: 16] = cnt_q[g];
    end

endmodule

// File: tb/tb_noisy_channel_mc.sv
// Scoreboard bench for noisy_channel_mc: the stimulus side runs a behavioural
// channel model and queues the expected out/err_flag/err_cnt for each edge;
// a monitor pops one entry per edge and compares it against the DUT.
module tb_noisy_channel_mc;

    localparam int          NCH  = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          BL   = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [NCH-1:0]   in_v, ch_en_v, stuck_v;
    logic [1:0]       mode_v;
    logic [7:0]       err_rate_v;
    logic             reseed_v, clr_v;
    logic [NCH-1:0]   out, err_flag;
    logic [16*NCH-1:0] err_cnt;

    always #5 clk = ~clk;

    noisy_channel_mc #(
        .NUM_CH(NCH), .SEED(SEED), .BURST_LEN(BL), .IDLE_VAL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_v), .ch_en(ch_en_v), .mode(mode_v),
        .err_rate(err_rate_v), .stuck_val(stuck_v), .reseed(reseed_v),
        .clr_cnt(clr_v), .out(out), .err_flag(err_flag), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [NCH-1:0] o;
        logic [NCH-1:0] f;
        logic [15:0]    c0;
        logic [15:0]    c1;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Behavioural model state
    logic [15:0]    m_lfsr [NCH];
    int             m_rem  [NCH];
    int             m_cnt  [NCH];
    logic [NCH-1:0] m_fprev;

    function automatic logic [15:0] seed_of(input int i);
        int s;
        s = ((int'(SEED) << i) | (int'(SEED) >> (16 - i))) & 32'h0000_FFFF;
        return 16'(s);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_lfsr[i] = seed_of(i);
            m_rem[i]  = 0;
            m_cnt[i]  = 0;
        end
        m_fprev = '0;
    endtask

    // Apply current inputs to the model, queue the expected result, then
    // advance to 2 time units after the next rising edge.
    task automatic go();
        exp_t           e;
        logic [NCH-1:0] no, nf;
        no = '0;
        nf = '0;
        for (int i = 0; i < NCH; i++) begin
            logic act, trig, flip;
            act  = ch_en_v[i] && (mode_v != 2'b00);
            trig = (m_lfsr[i][7:0] < err_rate_v);
            flip = 1'b0;
            if (act && mode_v == 2'b10) begin
                if (m_rem[i] > 0) begin
                    flip = 1'b1;
                    m_rem[i] = m_rem[i] - 1;
                end else if (trig) begin
                    flip = 1'b1;
                    m_rem[i] = BL - 1;
                end
            end else begin
                m_rem[i] = 0;
            end
            if (!act) begin
                no[i] = in_v[i];
                nf[i] = 1'b0;
            end else if (mode_v == 2'b01) begin
                no[i] = in_v[i] ^ trig;
                nf[i] = trig;
            end else if (mode_v == 2'b10) begin
                no[i] = in_v[i] ^ flip;
                nf[i] = flip;
            end else begin
                no[i] = stuck_v[i];
                nf[i] = stuck_v[i] ^ in_v[i];
            end
            if (clr_v) m_cnt[i] = 0;
            else if (m_fprev[i] && m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
            m_lfsr[i] = reseed_v ? seed_of(i) : lfsr_next(m_lfsr[i]);
        end
        m_fprev = nf;
        e.o  = no;
        e.f  = nf;
        e.c0 = 16'(m_cnt[0]);
        e.c1 = 16'(m_cnt[1]);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Async reset dropped between edges; checks immediate output values.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out", int'(out), 3);
        chk("rst_flag", int'(err_flag), 0);
        chk("rst_cnt", int'(err_cnt), 0);
        sb_q.delete();
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_out_flag", int'({out, err_flag}), int'({e.o, e.f}));
                chk("sb_cnt0", int'(err_cnt[15:0]), int'(e.c0));
                chk("sb_cnt1", int'(err_cnt[31:16]), int'(e.c1));
            end
        end
    end

    // Watchdog
    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        logic [NCH-1:0] rec1 [200];
        logic [NCH-1:0] rec2 [200];
        int  run [NCH];
        int  same, lanes_differ, found;

        in_v = '0; ch_en_v = '0; stuck_v = '0; mode_v = 2'b00;
        err_rate_v = 8'd0; reseed_v = 1'b0; clr_v = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("init_out", int'(out), 3);
        chk("init_flag", int'(err_flag), 0);
        chk("init_cnt", int'(err_cnt), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Pass-through
        ch_en_v = 2'($urandom);
        for (int j = 0; j < 100; j++) begin
            in_v = (j % 2 == 0) ? 2'b01 : 2'b10;
            go();
        end
        chk("pass_cnt", int'(err_cnt), 0);

        // Random rate from reset
        do_reset();
        mode_v = 2'b01; ch_en_v = 2'b11; err_rate_v = 8'd128;
        for (int j = 0; j < 4096; j++) begin
            in_v = 2'($urandom);
            go();
        end
        chk("rate_cnt0", int'(err_cnt[15:0]), m_cnt[0]);
        chk("rate_cnt1", int'(err_cnt[31:16]), m_cnt[1]);
        chk("rate_ballpark", int'(m_cnt[0] > 1600 && m_cnt[0] < 2500), 1);

        // err_rate = 0 never triggers
        err_rate_v = 8'd0; clr_v = 1'b1;
        go();
        clr_v = 1'b0;
        for (int j = 0; j < 300; j++) begin
            in_v = 2'($urandom);
            go();
        end
        chk("rate0_cnt", int'(err_cnt), 0);

        // Reseed determinism
        err_rate_v = 8'd128; in_v = '0;
        reseed_v = 1'b1; go(); reseed_v = 1'b0;
        for (int j = 0; j < 200; j++) begin go(); rec1[j] = out; end
        reseed_v = 1'b1; go(); reseed_v = 1'b0;
        for (int j = 0; j < 200; j++) begin go(); rec2[j] = out; end
        same = 1; lanes_differ = 0;
        for (int j = 0; j < 200; j++) begin
            if (rec1[j] !== rec2[j]) same = 0;
            if (rec1[j][0] !== rec1[j][1]) lanes_differ = 1;
        end
        chk("reseed_repeat", same, 1);
        chk("reseed_lanes_differ", lanes_differ, 1);

        // Burst
        mode_v = 2'b10; err_rate_v = 8'd16;
        for (int i = 0; i < NCH; i++) run[i] = 0;
        for (int j = 0; j < 1500; j++) begin
            in_v = 2'($urandom);
            go();
            for (int i = 0; i < NCH; i++) begin
                if (err_flag[i]) run[i]++;
                else if (run[i] > 0) begin
                    chk("burst_run_len", run[i] % BL, 0);
                    run[i] = 0;
                end
            end
        end
        found = 0;
        for (int j = 0; j < 500 && found == 0; j++) begin
            go();
            if (m_rem[0] > 0) found = 1;
        end
        chk("burst_found", found, 1);
        mode_v = 2'b00;
        go();
        chk("burst_abort_flag", int'(err_flag), 0);

        // Randomised mix of all controls
        for (int j = 0; j < 800; j++) begin
            in_v       = 2'($urandom);
            ch_en_v    = 2'($urandom);
            stuck_v    = 2'($urandom);
            err_rate_v = 8'($urandom);
            if ($urandom_range(0, 15) == 0) mode_v = 2'($urandom);
            reseed_v   = ($urandom_range(0, 63) == 0);
            clr_v      = ($urandom_range(0, 63) == 0);
            go();
        end
        reseed_v = 1'b0; clr_v = 1'b0;

        // Stuck-at and saturation
        mode_v = 2'b11; ch_en_v = 2'b11; stuck_v = 2'b00; in_v = 2'b00;
        clr_v = 1'b1; go(); clr_v = 1'b0;
        for (int j = 0; j < 10; j++) go();
        chk("stuck_in0_cnt", int'(err_cnt), 0);
        in_v = 2'b11;
        for (int j = 0; j < 65540; j++) go();
        chk("stuck_out", int'(out), 0);
        chk("sat_cnt0", int'(err_cnt[15:0]), 16'hFFFF);
        chk("sat_cnt1", int'(err_cnt[31:16]), 16'hFFFF);
        clr_v = 1'b1; go(); clr_v = 1'b0;
        chk("clr_wins", int'(err_cnt), 0);
        go();
        chk("count_after_clr", int'(err_cnt[15:0]), 1);

        // Async reset mid-burst
        mode_v = 2'b10; err_rate_v = 8'd255; in_v = 2'b00;
        for (int j = 0; j < 6; j++) go();
        chk("pre_rst_in_burst", int'(m_rem[0] > 0 || m_rem[1] > 0), 1);
        do_reset();
        err_rate_v = 8'd0;
        for (int j = 0; j < 10; j++) go();
        chk("no_residual_flag", int'(err_flag), 0);
        mode_v = 2'b01; err_rate_v = 8'd128;
        for (int j = 0; j < 300; j++) begin
            in_v = 2'($urandom);
            go();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
